shader_program_ring: RTL



---
 rtl/shader_program_ring.sv | 124 ++++++++++++
 1 files changed

// File: rtl/shader_program_ring.sv
// Circular instruction store for the tiny-shader core: the head word is presented combinationally,
// the ring rotates on shift, and a new program can be streamed in through a valid/ready load port.
module shader_program_ring #(
  parameter int                 INSTR_W   = 8,
  parameter int                 NUM_INSTR = 8,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(8'b0111_0000),
  parameter int                 PC_W      = $clog2(NUM_INSTR)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               shift_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               wrap_o,
  input  logic               load_start_i,
  input  logic               load_valid_i,
  input  logic [INSTR_W-1:0] load_data_i,
  output logic               load_ready_o,
  output logic               busy_o,
  output logic               load_done_o
);

  localparam int               CNT_W    = $clog2(NUM_INSTR + 1);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(NUM_INSTR - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_INSTR - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic [INSTR_W-1:0] mem_q [NUM_INSTR];
  logic [INSTR_W-1:0] mem_d [NUM_INSTR];
  logic               rotate;
  logic               accept;

  // A start request wins over a same-cycle shift, so rotation is suppressed then.
  always_comb begin
    rotate = (state_q == IDLE) && shift_i && !load_start_i;
    accept = (state_q == LOAD) && load_valid_i;
  end

  // Both rotation and loading move every word one place toward the head;
  // they differ only in what enters the tail.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_INSTR - 1; gi++) begin : g_body
      assign mem_d[gi] = (rotate || accept) ? mem_q[gi+1] : mem_q[gi];
    end
  endgenerate

  assign mem_d[NUM_INSTR-1] = rotate ? mem_q[0] :
                              accept ? load_data_i : mem_q[NUM_INSTR-1];

  generate
    for (gi = 0; gi < NUM_INSTR; gi++) begin : g_mem
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          mem_q[gi] <= NOP_INSTR;
        end else begin
          mem_q[gi] <= mem_d[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else if (shift_i) begin
          wrap_d = (pc_q == PC_LAST);
          pc_d   = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
        end
      end
      LOAD: begin
        if (load_valid_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            pc_d    = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign instr_o      = mem_q[0];
  assign pc_o         = pc_q;
  assign wrap_o       = wrap_q;
  assign load_ready_o = (state_q == LOAD);
  assign busy_o       = (state_q == LOAD);
  assign load_done_o  = done_q;

endmodule
